vga_scanout: RTL and testbench

Parametrised VGA scan-out engine, the next generation of the single-mode VGA output port. It generates programmable horizontal and vertical timing from `sysclk` through a pixel-clock-enable divider. It issues pixel coordinates to `NUM_SRC` pixel sources, absorbing their fixed read latency. It drives multi-bit RGB with sync aligned to the data, and switches between sources only on frame boundaries. It sits between the container switcher / pixel sources and the board VGA pins.

---
 rtl/vga_scanout.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: programmable VGA timing, multi-source fetch, aligned RGB/sync.
// Optional colour-bar generator: define VGA_TEST_PATTERN_EN.
module vga_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 1,
  parameter int NUM_SRC  = 2,
  parameter int RD_LAT   = 1,
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic                         sysclk,
  input  logic                         rst_n,
  input  logic                         sel_req,
  input  logic [SRC_W-1:0]             sel_src,
  input  logic [NUM_SRC*3*COLOR_W-1:0] pixel_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                         test_pat,
`endif
  output logic [X_W-1:0]               pixel_x,
  output logic [Y_W-1:0]               pixel_y,
  output logic                         pixel_req,
  output logic [COLOR_W-1:0]           VGA_R,
  output logic [COLOR_W-1:0]           VGA_G,
  output logic [COLOR_W-1:0]           VGA_B,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic                         blank,
  output logic                         frame_start,
  output logic [SRC_W-1:0]             active_src
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

`ifdef VGA_TEST_PATTERN_EN
  localparam int FW = SRC_W + 7;
`else
  localparam int FW = SRC_W + 3;
`endif

  logic             pix_tick;
  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             at_origin;
  logic             origin_tick;
  logic             act;
  logic             hs_on;
  logic             vs_on;
  logic [SRC_W-1:0] pending;
  logic             pend_vld;
  logic [SRC_W-1:0] cur_src;
  logic [SRC_W-1:0] src_eff;
  logic             sel_ok;
  logic [FW-1:0]    cnt_flags;
  logic [FW-1:0]    aln_flags;
  logic             a_act;
  logic             a_hs;
  logic             a_vs;
  logic [SRC_W-1:0] a_src;
  logic [PW-1:0]    src_rgb;
  logic [PW-1:0]    pix_rgb;

  generate
    if (CLK_DIV == 1) begin : g_div1
      assign pix_tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_cnt;
      // pixel-clock-enable divider
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
          div_cnt <= '0;
        else if (div_cnt == D_LAST)
          div_cnt <= '0;
        else
          div_cnt <= div_cnt + 1'b1;
      end
      assign pix_tick = (div_cnt == D_LAST);
    end
  endgenerate

  // raster counters: h wraps per line, v advances on h wrap
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST)
          v_cnt <= '0;
        else
          v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign at_origin   = (h_cnt == '0) && (v_cnt == '0);
  assign origin_tick = pix_tick && at_origin;
  assign act         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  assign pixel_x     = h_cnt[X_W-1:0];
  assign pixel_y     = v_cnt[Y_W-1:0];
  assign pixel_req   = act && rst_n;
  assign frame_start = origin_tick && rst_n;

  assign sel_ok  = int'(sel_src) < NUM_SRC;
  // the origin pixel already uses a pending switch so the frame is uniform
  assign src_eff = (at_origin && pend_vld) ? pending : cur_src;

  // source select: latch last valid request, commit at frame origin
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_vld <= 1'b0;
      cur_src  <= '0;
    end else begin
      if (origin_tick) begin
        if (pend_vld)
          cur_src <= pending;
        pend_vld <= 1'b0;
      end
      if (sel_req && sel_ok) begin
        pending  <= sel_src;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       tp_cur;
  logic       tp_eff;
  logic [2:0] bar_idx;
  logic       a_tp;
  logic [2:0] a_bar;
  logic [PW-1:0] bar_rgb;

  assign tp_eff  = at_origin ? test_pat : tp_cur;
  assign bar_idx = 3'((int'(h_cnt) * 8) / H_ACTIVE);

  // test-pattern enable is frame-granular like the source index
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      tp_cur <= 1'b0;
    else if (origin_tick)
      tp_cur <= test_pat;
  end

  assign cnt_flags = {bar_idx, tp_eff, src_eff, vs_on, hs_on, act};
  assign a_tp      = aln_flags[SRC_W+3];
  assign a_bar     = aln_flags[SRC_W+4 +: 3];
  assign bar_rgb   = {{COLOR_W{a_bar[2]}},
                      {COLOR_W{a_bar[1]}},
                      {COLOR_W{a_bar[0]}}};
  assign pix_rgb   = a_tp ? bar_rgb : src_rgb;
`else
  assign cnt_flags = {src_eff, vs_on, hs_on, act};
  assign pix_rgb   = src_rgb;
`endif

  generate
    if (RD_LAT == 0) begin : g_nodl
      assign aln_flags = cnt_flags;
    end else begin : g_dl
      logic [FW-1:0] dl [RD_LAT];
      // delay line covering the source read latency
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LAT; i++)
            dl[i] <= '0;
        end else if (pix_tick) begin
          dl[0] <= cnt_flags;
          for (int i = 1; i < RD_LAT; i++)
            dl[i] <= dl[i-1];
        end
      end
      assign aln_flags = dl[RD_LAT-1];
    end
  endgenerate

  assign a_act = aln_flags[0];
  assign a_hs  = aln_flags[1];
  assign a_vs  = aln_flags[2];
  assign a_src = aln_flags[3 +: SRC_W];

  // pick the displayed source slice out of the packed input
  always_comb begin
    src_rgb = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (a_src == SRC_W'(k))
        src_rgb = pixel_data[k*PW +: PW];
  end

  // pin register: final stage of the alignment pipeline
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      blank      <= 1'b1;
      VGA_HS     <= ~HS_ON;
      VGA_VS     <= ~VS_ON;
      active_src <= '0;
    end else if (pix_tick) begin
      {VGA_R, VGA_G, VGA_B} <= a_act ? pix_rgb : '0;
      blank      <= ~a_act;
      VGA_HS     <= a_hs ? HS_ON : ~HS_ON;
      VGA_VS     <= a_vs ? VS_ON : ~VS_ON;
      active_src <= a_src;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random source-select traffic checked against a
// position/frame-level reference model of the scan-out.
module tb_vga_scanout;
  localparam int HT = 16;
  localparam int FT = HT * 8;
  localparam int NS = 3;
  localparam int CW = 2;

  logic             sysclk = 1'b0;
  logic             rst_n = 1'b1;
  logic             sel_req = 1'b0;
  logic [1:0]       sel_src = '0;
  logic [NS*3*CW-1:0] pixel_data = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic             test_pat = 1'b0;
  bit               frame_tp [64];
`endif
  logic [2:0]       pixel_x;
  logic [1:0]       pixel_y;
  logic             pixel_req;
  logic [CW-1:0]    vga_r;
  logic [CW-1:0]    vga_g;
  logic [CW-1:0]    vga_b;
  logic             vga_hs;
  logic             vga_vs;
  logic             blank;
  logic             frame_start;
  logic [1:0]       active_src;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [4:0] hist [$];
  int         pend = 0;
  bit         pend_v = 0;
  int         frame_src [64];
  logic [5:0] mask [NS];

  vga_scanout #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(CW), .NUM_SRC(NS), .RD_LAT(2)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .sel_req(sel_req),
    .sel_src(sel_src), .pixel_data(pixel_data),
`ifdef VGA_TEST_PATTERN_EN
    .test_pat(test_pat),
`endif
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .blank(blank),
    .frame_start(frame_start), .active_src(active_src)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int srcval(input int k, input int x, input int y);
    return (((x & 3) << 4) | ((y & 3) << 2) | 3) ^ int'(mask[k]);
  endfunction

  function automatic bit act_at(input int q);
    return ((q % HT) < 8) && (((q / HT) % 8) < 4);
  endfunction

  // pins show the position that left the counters three ticks ago
  task automatic check_pins();
    int p, hc, vc, f, rgb_e, hs_e, vs_e, bl_e, as_e;
    bit a;
    p = cyc / 2 - 3;
    if (p < 0) begin
      rgb_e = 0; hs_e = 1; vs_e = 1; bl_e = 1; as_e = 0;
    end else begin
      hc = p % HT;
      vc = (p / HT) % 8;
      f  = p / FT;
      a  = act_at(p);
      hs_e  = (hc >= 10 && hc < 13) ? 0 : 1;
      vs_e  = (vc >= 5 && vc < 7) ? 0 : 1;
      bl_e  = a ? 0 : 1;
      as_e  = frame_src[f];
      rgb_e = a ? srcval(frame_src[f], hc, vc) : 0;
`ifdef VGA_TEST_PATTERN_EN
      if (a && frame_tp[f])
        rgb_e = (((hc >> 2) & 1) * 3 << 4) | (((hc >> 1) & 1) * 3 << 2)
              | ((hc & 1) * 3);
      if (a && frame_tp[f] && hc == 5)
        check("bar5", 32'({vga_r, vga_g, vga_b}), 32'h33);
      if (!frame_tp[f])
`endif
      if (hc == 5 && vc == 2 && frame_src[f] == 0)
        check("pix_5_2", 32'({vga_r, vga_g, vga_b}), 32'h1B);
    end
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb_e));
    check("hs", 32'(vga_hs), 32'(hs_e));
    check("vs", 32'(vga_vs), 32'(vs_e));
    check("blank", 32'(blank), 32'(bl_e));
    check("active_src", 32'(active_src), 32'(as_e));
  endtask

  // one sysclk: check, play the source, issue the request for next edge
  task automatic step(input bit req, input int src);
    int q, f, x, y;
    bit tk;
    logic [4:0] h;
    @(negedge sysclk);
    if (rst_n) cyc++;
    check_pins();
    q  = cyc / 2;
    tk = rst_n && (cyc % 2 == 1);
    check("pixel_req", 32'(pixel_req), 32'(rst_n && act_at(q)));
    check("pixel_x", 32'(pixel_x), 32'((q % HT) & 7));
    check("pixel_y", 32'(pixel_y), 32'(((q / HT) % 8) & 3));
    check("frame_start", 32'(frame_start), 32'(tk && (q % FT == 0)));
    if (tk) begin
      if (q % FT == 0) begin
        f = q / FT;
        frame_src[f] = pend_v ? pend : ((f > 0) ? frame_src[f-1] : 0);
        pend_v = 0;
`ifdef VGA_TEST_PATTERN_EN
        frame_tp[f] = test_pat;
`endif
      end
      hist.push_back({pixel_x, pixel_y});
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3) begin
        h = hist[0];
        x = int'(h[4:2]);
        y = int'(h[1:0]);
        pixel_data = {6'(srcval(2, x, y)), 6'(srcval(1, x, y)),
                      6'(srcval(0, x, y))};
      end
    end
    if (req && src < NS && rst_n) begin
      pend   = src;
      pend_v = 1;
    end
    sel_req = req;
    sel_src = 2'(src);
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    cyc    = 0;
    pend_v = 0;
    hist.delete();
    for (int i = 0; i < 64; i++) begin
      frame_src[i] = 0;
`ifdef VGA_TEST_PATTERN_EN
      frame_tp[i] = 0;
`endif
    end
    #1;
    check_pins();
    check("rst_pixel_req", 32'(pixel_req), 32'(0));
    check("rst_frame_start", 32'(frame_start), 32'(0));
    repeat (n) step(1'b0, 0);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 600; i++) begin
      if ((cyc / 2) % FT == pos && cyc % 2 == 0) break;
      step(1'b0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    mask[0] = '0;
    mask[1] = 6'($urandom);
    mask[2] = 6'($urandom);
    #2;
    do_reset(4);
    run(2 * 256);
    run_to(2 * HT + 3);
    step(1'b1, 2);
    run(2 * 256);
    run_to(HT);
    step(1'b1, 3);
    run(7);
    step(1'b1, 1);
    run(9);
    step(1'b1, 3);
    run(2 * 256);
    run_to(0);
    step(1'b1, 2);
    run(2 * 256);
    for (int i = 0; i < 6 * 256; i++)
      step($urandom_range(63) == 0, int'($urandom_range(3)));
    run_to(3 * HT + 5);
    do_reset(3);
    run(300);
`ifdef VGA_TEST_PATTERN_EN
    test_pat = 1'b1;
    run(2 * 256);
    test_pat = 1'b0;
    run(300);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
